mem_req_master: RTL

- Upstream requester for the single-port memory slave on axi_interface.
- Accepts read/write commands from a controller or sequencer into a small queue.
- Issues each command on the memory valid/ready handshake, then returns one response per command with read data or a timeout error.
- Sits directly in front of the memory slave and drives its valid, wr_rd_en, addr and wdata.

---
 rtl/mem_req_pkg.sv | 21 ++
 rtl/mem_req_master_if.sv | 37 +++
 rtl/mem_req_master_req_fifo.sv | 64 ++++++
 rtl/mem_req_master.sv | 117 +++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared types for the memory request master: bus widths, FSM state and the
// queued command word.
package mem_req_pkg;

   localparam int WIDTH      = 8;
   localparam int DEPTH      = 16;
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [WIDTH-1:0]      wdata;
   } cmd_t;

endpackage

// File: rtl/mem_req_master_if.sv
// Command, response and memory-side signals of the request master.
// Handshakes: a transfer happens on a posedge where valid and ready are both high;
// once raised, valid and its payload stay stable until that transfer happens.
interface mem_req_master_if;
   import mem_req_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_wr;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [WIDTH-1:0]      cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_wr;
   logic                  rsp_err;
   logic [WIDTH-1:0]      rsp_rdata;

   logic                  mem_valid;
   logic                  mem_ready;
   logic                  mem_wr_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]      mem_wdata;
   logic [WIDTH-1:0]      mem_rdata;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, mem_ready, mem_rdata,
      output cmd_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata,
             mem_valid, mem_wr_rd_en, mem_addr, mem_wdata
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, mem_ready, mem_rdata,
      input  cmd_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata,
             mem_valid, mem_wr_rd_en, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_req_master_req_fifo.sv
// Registered command FIFO; pointers wrap naturally because QDEPTH is a power of two.
module req_fifo
   import mem_req_pkg::*;
#(
   parameter  int QDEPTH = 4,
   localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
   localparam int CNT_W  = $clog2(QDEPTH + 1)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             push_i,
   input  cmd_t             push_data_i,
   input  logic             pop_i,
   output cmd_t             head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   cmd_t             slots_q [QDEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(QDEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = slots_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: a flushed count makes every slot unreachable.
   always_ff @(posedge clk) begin
      if (do_push) slots_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/mem_req_master.sv
// Queues read/write commands and issues them one at a time on the memory
// valid/ready handshake, returning one response pulse per command.
module mem_req_master
   import mem_req_pkg::*;
#(
   parameter  int QDEPTH  = 4,
   parameter  int TIMEOUT = 15,
   localparam int CNT_W   = $clog2(QDEPTH + 1),
   localparam int TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
   input  logic             clk,
   input  logic             res,
   mem_req_master_if.master bus,
   output state_e           state_o,
   output logic [CNT_W-1:0] q_count_o
);

   cmd_t             push_cmd;
   cmd_t             head;
   logic             fifo_full, fifo_empty;
   logic             do_push, do_pop;
   logic             timed_out;

   state_e           state_q;
   logic [TMR_W-1:0] timer_q;
   logic             mem_valid_q;
   logic             mem_wr_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [WIDTH-1:0] mem_wdata_q;
   logic             rsp_valid_q;
   logic             rsp_wr_q;
   logic             rsp_err_q;
   logic [WIDTH-1:0] rsp_rdata_q;

   assign push_cmd  = {bus.cmd_wr, bus.cmd_addr, bus.cmd_wdata};
   assign do_push   = bus.cmd_valid && !fifo_full;
   assign timed_out = (timer_q == TMR_W'(TIMEOUT - 1));
   // The head stays queued while in flight and leaves on the cycle REQ completes.
   assign do_pop    = (state_q == REQ) && (bus.mem_ready || timed_out);

   req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk         (clk),
      .res         (res),
      .push_i      (do_push),
      .push_data_i (push_cmd),
      .pop_i       (do_pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (q_count_o)
   );

   always_ff @(posedge clk) begin
      if (res) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         mem_valid_q <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  mem_valid_q <= 1'b1;
                  mem_wr_q    <= head.wr;
                  mem_addr_q  <= head.addr;
                  mem_wdata_q <= head.wdata;
                  timer_q     <= '0;
                  state_q     <= REQ;
               end
            end
            REQ: begin
               if (bus.mem_ready) begin
                  mem_valid_q <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_wr_q    <= mem_wr_q;
                  rsp_rdata_q <= mem_wr_q ? '0 : bus.mem_rdata;
                  state_q     <= DRAIN;
               end else if (timed_out) begin
                  mem_valid_q <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_wr_q    <= mem_wr_q;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  state_q     <= DRAIN;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            // A ready left high from the last access must never count as the next handshake.
            DRAIN: begin
               if (!bus.mem_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready    = !fifo_full;
   assign bus.mem_valid    = mem_valid_q;
   assign bus.mem_wr_rd_en = mem_wr_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_wr       = rsp_wr_q;
   assign bus.rsp_err      = rsp_err_q;
   assign bus.rsp_rdata    = rsp_rdata_q;
   assign state_o          = state_q;

endmodule
